ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte from the FPGA to a PS/2 keyboard or mouse, e.g. 0xED LED set, 0xF4 mouse enable, 0xFF reset.
- Covers the direction our keyboard scan path does not: the keyboard path only receives.
- Runs on clk7 next to the keyboard/mode-switch logic.
- Drives the open-drain clock and data lines through active-high "pull low" enables. The top level builds the inouts as `x = drive_low ? 1'b0 : 1'bz`.

Parameters:
- CLKFREQ_KHZ, 7000, frequency of clk in kHz.
- INHIBIT_US, 100, time the host holds the clock low before request-to-send.
- TIMEOUT_US, 15000, watchdog limit between consecutive device clock falling edges, and for the final bus-idle wait.
- FILTER_LEN, 8, number of stable samples the glitch filter requires (used only with PS2TX_GLITCH_FILTER_EN).

Ports:
- clk  in  1  system clock (clk7 in the test top).
- rst  in  1  synchronous reset, active-high.
- ps2clk_in  in  1  raw PS/2 clock line (asynchronous).
- ps2data_in  in  1  raw PS/2 data line (asynchronous).
- ps2clk_low  out  1  1 = pull clock line low.
- ps2data_low  out  1  1 = pull data line low.
- tx_data  in  8  byte to send; sampled when the send strobe is accepted.
- send  in  1  1-cycle request strobe.
- busy  out  1  high from acceptance until done or error.
- done  out  1  1-cycle pulse: byte acknowledged by device, bus idle.
- error  out  1  1-cycle pulse: transfer aborted.
- err_code  out  2  valid with error, held until next accept: 01 timeout, 10 NACK, 00 none.

Behaviour:
- Reset values: ps2clk_low=0, ps2data_low=0, busy=0, done=0, error=0, err_code=00, state=IDLE.
- Reset mid-transfer releases both lines on the next clk edge and produces no done or error.
- Line conditioning: both inputs pass through a 2-FF synchronizer. A clock falling edge (fall) is a 1→0 change of the synchronized clock, detected one cycle later.
- Parity: odd over tx_data. Bits are sent LSB first.
- Derived counts: INHIBIT_CYC = CLKFREQ_KHZ*INHIBIT_US/1000 (700 at defaults). TIMEOUT_CYC = CLKFREQ_KHZ*TIMEOUT_US/1000 (105000 at defaults). Counter width = $clog2(max)+1.
- IDLE:
  - send=1 latches tx_data into a shift register, sets busy=1 and clears err_code.
  - The next cycle enters INHIBIT.
  - send while busy=1 is ignored and the latched byte is unchanged.
- INHIBIT: ps2clk_low=1. After INHIBIT_CYC cycles, set ps2data_low=1 (start bit) and go to RTS.
- RTS: ps2clk_low=0 (data still low) for 1 cycle, then go to BITS with bitcnt=0 and the watchdog cleared.
- BITS, on each fall:
  - bitcnt 0..7: present data bit bitcnt; drive low when the bit is 0, release when it is 1.
  - bitcnt 8: present parity.
  - bitcnt 9: release data (stop bit).
  - bitcnt increments each fall. At bitcnt=10, go to ACK.
- ACK: on the next fall, sample synchronized data.
  - 0 → go to WAIT_IDLE.
  - 1 → error=1, err_code=10, go to IDLE.
- WAIT_IDLE: when synchronized clock=1 and data=1, pulse done=1, busy=0, go to IDLE.
- Watchdog:
  - Applies in BITS, ACK and WAIT_IDLE.
  - It is cleared on every fall. If it reaches TIMEOUT_CYC, release both lines, error=1, err_code=01, go to IDLE.
- On error or done, busy drops in the same cycle as the pulse.
- A send in that same cycle is not accepted.
- A send on the following cycle is accepted.
- Data changes only in the cycle after a detected fall, i.e. while the device clock is low. Setup before the device's rising-edge sample is guaranteed at ≥100 kHz clk.

Optional Feature:
- PS2TX_GLITCH_FILTER_EN defined: the synchronized clock feeds a filter that changes its output only after FILTER_LEN consecutive identical samples. Edge detection uses the filtered signal, adding FILTER_LEN cycles of latency to each fall.
- Undefined: raw 2-FF synchronized clock; no filter logic instantiated.

Decomposition:
- Package ps2_pkg holds:
  - state enum IDLE, INHIBIT, RTS, BITS, ACK, WAIT_IDLE;
  - err_code constants ERR_NONE, ERR_TIMEOUT, ERR_NACK;
  - a cycle-count helper function (kHz, µs → cycles).
- Sub-module ps2_line_sync contains the synchronizer, the optional filter and the fall detector. The same block is reusable by the keyboard and mouse receivers.

Test Plan:
- Send 0xED; device model clocks at 12.5 kHz and ACKs.
  - Clock is held low for 700±2 cycles.
  - Device samples 0, then 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
  - done pulses once and busy falls with it.
- Send 0x01: parity bit sampled = 0. Send 0xFF: parity bit sampled = 1.
- Device never clocks after RTS → at 105000 cycles error=1, err_code=01, both line outputs 0.
- Device holds data high on the 11th clock (no ACK) → error=1, err_code=10, done never asserted.
- send pulsed again with 0x55 during the 0xF4 transfer → device receives 0xF4 only, exactly one done.
- rst asserted at bitcnt=4 → next cycle ps2clk_low=ps2data_low=0, busy=0, no done/error; a following send of 0xF4 completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM states, error codes and timing helper for the PS/2 blocks.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        BITS,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NACK    = 2'b10;

    // Converts a duration in microseconds to clock cycles at the given kHz rate.
    function automatic int us_to_cycles(input int khz, input int us);
        return khz * us / 1000;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: conditions raw PS/2 clock/data lines and flags device clock falls.
//   Build option: PS2TX_GLITCH_FILTER_EN adds a FILTER_LEN-sample stability filter on the clock.
//   Ports: clk, rst       system clock, synchronous active-high reset
//          ps2clk_i       raw asynchronous PS/2 clock line
//          ps2data_i      raw asynchronous PS/2 data line
//          clk_o          conditioned clock level
//          data_o         synchronized data level
//          fall_o         one-cycle flag: conditioned clock went 1->0
module ps2_line_sync #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2clk_i,
    input  logic ps2data_i,
    output logic clk_o,
    output logic data_o,
    output logic fall_o
);

    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       clk_prev_q;
    logic       clk_filt;

    // Idle bus is high, so flops come out of reset high to avoid a false fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2clk_i};
            data_sync_q <= {data_sync_q[0], ps2data_i};
            clk_prev_q  <= clk_filt;
        end
    end

`ifdef PS2TX_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN) + 1;

    logic [FW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;

    // Output flips only after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (clk_sync_q[1] != filt_q) begin
            if (cnt_q == FW'(FILTER_LEN - 1))
                filt_d = clk_sync_q[1];
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign clk_filt = filt_q;
`else
    localparam int unused_filter_len = FILTER_LEN;

    assign clk_filt = clk_sync_q[1];
`endif

    assign clk_o  = clk_filt;
    assign data_o = data_sync_q[1];
    assign fall_o = clk_prev_q & ~clk_filt;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter sending one command byte per send strobe.
//   Build option: PS2TX_GLITCH_FILTER_EN enables the clock glitch filter in ps2_line_sync.
//   Ports: clk, rst                 system clock, synchronous active-high reset
//          ps2clk_in, ps2data_in    raw open-drain line levels
//          ps2clk_low, ps2data_low  1 = pull the line low
//          tx_data, send            byte and one-cycle request strobe
//          busy, done, error        status; done/error are one-cycle pulses
//          err_code                 01 timeout, 10 NACK, held until next accept
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLKFREQ_KHZ = 7000,
    parameter int INHIBIT_US  = 100,
    parameter int TIMEOUT_US  = 15000,
    parameter int FILTER_LEN  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_low,
    output logic       ps2data_low,
    input  logic [7:0] tx_data,
    input  logic       send,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);

    localparam int INHIBIT_CYC = us_to_cycles(CLKFREQ_KHZ, INHIBIT_US);
    localparam int TIMEOUT_CYC = us_to_cycles(CLKFREQ_KHZ, TIMEOUT_US);
    localparam int MAX_CYC     = INHIBIT_CYC > TIMEOUT_CYC ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int CW          = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);

    logic clk_s, data_s, fall;

    ps2_line_sync #(
        .FILTER_LEN (FILTER_LEN)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .ps2clk_i  (ps2clk_in),
        .ps2data_i (ps2data_in),
        .clk_o     (clk_s),
        .data_o    (data_s),
        .fall_o    (fall)
    );

    ps2_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          parity_q, parity_d;
    logic          clk_low_q, clk_low_d;
    logic          data_low_q, data_low_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [1:0]    err_q, err_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        parity_d   = parity_q;
        clk_low_d  = clk_low_q;
        data_low_d = data_low_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                // A send coinciding with the done/error pulse is dropped.
                if (send && !done_q && !error_q) begin
                    shreg_d   = tx_data;
                    parity_d  = ~^tx_data;
                    busy_d    = 1'b1;
                    err_d     = ERR_NONE;
                    clk_low_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    clk_low_d  = 1'b0;
                    data_low_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = RTS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RTS: begin
                bitcnt_d = '0;
                cnt_d    = '0;
                state_d  = BITS;
            end
            BITS: begin
                // Data moves right after a fall, while the device holds its clock low.
                if (fall) begin
                    bitcnt_d   = bitcnt_q + 1'b1;
                    data_low_d = bitcnt_q < 4'd8  ? ~shreg_q[bitcnt_q[2:0]] :
                                 bitcnt_q == 4'd8 ? ~parity_q : 1'b0;
                    state_d    = bitcnt_q == 4'd9 ? ACK : BITS;
                end
            end
            ACK: begin
                if (fall) begin
                    if (data_s) begin
                        data_low_d = 1'b0;
                        error_d    = 1'b1;
                        err_d      = ERR_NACK;
                        busy_d     = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Watchdog measures the gap between device clock falls; it overrides a same-cycle done.
        if (state_q inside {BITS, ACK, WAIT_IDLE}) begin
            cnt_d = fall ? '0 : cnt_q + 1'b1;
            if (!fall && cnt_q == TIMEOUT_LAST) begin
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                done_d     = 1'b0;
                error_d    = 1'b1;
                err_d      = ERR_TIMEOUT;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_q      <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            clk_low_q  <= clk_low_d;
            data_low_q <= data_low_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_q      <= err_d;
        end
    end

    assign ps2clk_low  = clk_low_q;
    assign ps2data_low = data_low_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign err_code    = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a PS/2 device model and a done/error scoreboard.
module tb_ps2_host_tx;

    localparam int HALF = 280;           // 12.5 kHz device clock at 7 MHz
    localparam int TC   = 7000;          // watchdog cycles with TIMEOUT_US=1000 (shortened run)

    typedef struct packed {
        logic       is_err;
        logic [1:0] code;
    } resp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2clk_in, ps2data_in;
    logic       ps2clk_low, ps2data_low, busy, done, error;
    logic [1:0] err_code;

    resp_t exp_q[$];
    resp_t mon_e;
    int errors = 0, checks = 0;
    int low_cnt = 0, last_low = 0, done_cnt = 0, err_cnt = 0;
    int n, d0, e0;

    // Open-drain bus: either side pulling low wins.
    assign ps2clk_in  = dev_clk & ~ps2clk_low;
    assign ps2data_in = dev_data & ~ps2data_low;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLKFREQ_KHZ (7000),
        .INHIBIT_US  (100),
        .TIMEOUT_US  (1000),
        .FILTER_LEN  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2clk_in   (ps2clk_in),
        .ps2data_in  (ps2data_in),
        .ps2clk_low  (ps2clk_low),
        .ps2data_low (ps2data_low),
        .tx_data     (tx_data),
        .send        (send),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic resp_t mk(input logic is_err, input logic [1:0] code);
        resp_t r;
        r.is_err = is_err;
        r.code   = code;
        return r;
    endfunction

    // Monitor: clock-low length tracking and scoreboard pop on every done/error pulse.
    always @(negedge clk) begin
        if (ps2clk_low) low_cnt++;
        else if (low_cnt != 0) begin
            last_low = low_cnt;
            low_cnt  = 0;
        end
        if (done) done_cnt++;
        if (error) err_cnt++;
        if (done || error) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp: unexpected done=%0b error=%0b code=%0b", done, error, err_code);
            end else begin
                mon_e = exp_q.pop_front();
                if (done == error || error !== mon_e.is_err || busy !== 1'b0 ||
                    (error && err_code !== mon_e.code)) begin
                    errors++;
                    $display("FAIL resp: got done=%0b error=%0b code=%0b busy=%0b expected error=%0b code=%0b busy=0",
                             done, error, err_code, busy, mon_e.is_err, mon_e.code);
                end
            end
        end
    end

    // Device side of a host-to-device frame: start, 8 data, parity, stop, then ACK clock.
    task automatic dev_rx(input bit ack, output logic [10:0] bits, output bit ok);
        int w;
        w    = 0;
        bits = '0;
        ok   = 1'b0;
        while (!(ps2clk_in && !ps2data_in) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (!(ps2clk_in && !ps2data_in)) return;
        ok = 1'b1;
        repeat (HALF) @(negedge clk);
        bits[0] = ps2data_in;
        for (int k = 1; k <= 10; k++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            repeat (HALF - 20) @(negedge clk);
            bits[k] = ps2data_in;
            if (k == 10) dev_data = !ack;
            repeat (20) @(negedge clk);
        end
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        repeat (20) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while (busy && w < 20000) begin
            @(negedge clk);
            w++;
        end
        chk(name, busy, 1'b0);
    endtask

    task automatic xfer(input logic [7:0] d, input bit par, input bit ack, input bit do_send, input bit dup);
        logic [10:0] bits;
        bit          ok;
        exp_q.push_back(mk(!ack, ack ? 2'b00 : 2'b10));
        if (do_send) begin
            send    = 1'b1;
            tx_data = d;
            @(negedge clk);
            send    = 1'b0;
            tx_data = 8'h00;
        end
        if (dup) begin
            repeat (100) @(negedge clk);
            send    = 1'b1;
            tx_data = 8'h55;
            @(negedge clk);
            send    = 1'b0;
            tx_data = 8'h00;
        end
        dev_rx(ack, bits, ok);
        chk("rts_seen", ok, 1'b1);
        chk("frame", bits, {1'b1, par, d, 1'b0});
        wait_idle("busy_release");
        chk_rng("clk_low_cycles", last_low, 698, 702);
    endtask

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL global_timeout: bench exceeded its cycle budget");
        $fatal(1);
    end

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_ps2clk_low", ps2clk_low, 1'b0);
        chk("rst_ps2data_low", ps2data_low, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_err_code", err_code, 2'b00);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 0xED: 1,0,1,1,0,1,1,1 LSB first, odd parity 1
        xfer(8'hED, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("done_with_busy_fall", done, 1'b1);
        send    = 1'b1;
        tx_data = 8'h01;
        @(negedge clk);
        chk("send_in_done_cycle_ignored", busy, 1'b0);
        @(negedge clk);
        chk("send_next_cycle_accepted", busy, 1'b1);
        send    = 1'b0;
        tx_data = 8'h00;
        xfer(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        xfer(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);

        // Silent device: watchdog fires TC cycles after RTS
        repeat (10) @(negedge clk);
        exp_q.push_back(mk(1'b1, 2'b01));
        send    = 1'b1;
        tx_data = 8'hF4;
        @(negedge clk);
        send    = 1'b0;
        n       = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk_rng("timeout_cycles", n, 701 + TC - 2, 701 + TC + 2);
        chk("timeout_error", error, 1'b1);
        chk("timeout_code", err_code, 2'b01);
        chk("timeout_clk_released", ps2clk_low, 1'b0);
        chk("timeout_data_released", ps2data_low, 1'b0);
        repeat (5) @(negedge clk);
        chk("err_code_held", err_code, 2'b01);

        // 0x55 (parity 1) with the device leaving data high on the ACK clock
        repeat (10) @(negedge clk);
        d0 = done_cnt;
        xfer(8'h55, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("nack_code", err_code, 2'b10);
        chk("nack_no_done", done_cnt - d0, 0);

        // 0xF4 (parity 0) with a stray 0x55 send while busy
        repeat (10) @(negedge clk);
        d0 = done_cnt;
        xfer(8'hF4, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (200) @(negedge clk);
        chk("single_done", done_cnt - d0, 1);

        // Reset after the 4th device fall (bitcnt=4), then a clean retry
        d0      = done_cnt;
        e0      = err_cnt;
        send    = 1'b1;
        tx_data = 8'hF4;
        @(negedge clk);
        send    = 1'b0;
        tx_data = 8'h00;
        n       = 0;
        while (!(ps2clk_in && !ps2data_in) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_rts_seen", ps2clk_in && !ps2data_in, 1'b1);
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        chk("mid_bit3_low", ps2data_low, 1'b1);
        chk("mid_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_clk_released", ps2clk_low, 1'b0);
        chk("mid_rst_data_released", ps2data_low, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (4 * HALF) @(negedge clk);
        chk("mid_rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        xfer(8'hF4, 1'b0, 1'b1, 1'b1, 1'b0);

        repeat (50) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
